// File: rtl/imem_loader_fetch.sv
// Instruction memory with a byte-stream program loader and combinational fetch.
// The core is held in reset until the final program byte has been accepted.
module imem_loader_fetch #(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [7:0]  load_byte,
   input  logic        load_last,
   input  logic [31:0] pc_addr,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        fetch_fault,
   output logic        load_overflow,
   output logic        core_rst_n,
   output logic [31:0] bytes_loaded
);

   localparam int          AW      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] CAP     = 32'(DEPTH_WORDS * 4);
   localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

   typedef enum logic {LOAD, RUN} state_t;

   state_t        state_q, state_d;
   logic [31:0]   bytes_q, bytes_d;
   logic [23:0]   asm_q, asm_d;
   logic          ovf_q, ovf_d;
   logic          core_rst_n_q, core_rst_n_d;
   logic [31:0]   mem_q [DEPTH_WORDS];

   logic          accept;
   logic [1:0]    lane;
   logic [31:0]   word;
   logic          we;
   logic [AW-1:0] waddr;
   logic [31:0]   wdata;
   logic          fetch_ok;

   always_comb begin
      state_d      = state_q;
      bytes_d      = bytes_q;
      asm_d        = asm_q;
      ovf_d        = ovf_q;
      core_rst_n_d = (state_q == RUN);
      we           = 1'b0;
      waddr        = bytes_q[AW+1:2];
      wdata        = 32'h0;
      accept       = load_valid && (state_q == LOAD) && !rst;
      lane         = bytes_q[1:0];
      // Lanes above the current one are zero so a short final word pads cleanly
      case (lane)
         2'd0:    word = {24'h0, load_byte};
         2'd1:    word = {16'h0, load_byte, asm_q[7:0]};
         2'd2:    word = {8'h0, load_byte, asm_q[15:0]};
         default: word = {load_byte, asm_q[23:0]};
      endcase
      if (accept) begin
         asm_d   = word[23:0];
         bytes_d = bytes_q + 32'd1;
         if (bytes_q >= CAP) begin
            ovf_d = 1'b1;
         end else if (lane == 2'd3 || load_last) begin
            we    = 1'b1;
            wdata = word;
         end
         if (load_last) state_d = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= LOAD;
         bytes_q      <= 32'h0;
         asm_q        <= 24'h0;
         ovf_q        <= 1'b0;
         core_rst_n_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bytes_q      <= bytes_d;
         asm_q        <= asm_d;
         ovf_q        <= ovf_d;
         core_rst_n_q <= core_rst_n_d;
      end
   end

   // Storage survives rst so a reload can leave stale words behind
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   always_comb begin
      fetch_ok    = (pc_addr[1:0] == 2'b00) && ((pc_addr >> 2) < DEPTH32);
      instr       = NOP_INSTR;
      instr_valid = 1'b0;
      fetch_fault = 1'b0;
      if (state_q == RUN) begin
         if (fetch_ok) begin
            instr       = mem_q[pc_addr[AW+1:2]];
            instr_valid = 1'b1;
         end else begin
            fetch_fault = 1'b1;
         end
      end
   end

   assign load_ready    = (state_q == LOAD);
   assign load_overflow = ovf_q;
   assign core_rst_n    = core_rst_n_q;
   assign bytes_loaded  = bytes_q;

endmodule

// File: tb/tb_imem_loader_fetch.sv
// Bench for imem_loader_fetch: table-driven fetch vectors, a byte-level
// reference model and a queue scoreboard for fetch results.
module tb_imem_loader_fetch;

   localparam int          D   = 16;
   localparam int          CAP = D * 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        load_valid;
   logic        load_ready;
   logic [7:0]  load_byte;
   logic        load_last;
   logic [31:0] pc_addr;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fetch_fault;
   logic        load_overflow;
   logic        core_rst_n;
   logic [31:0] bytes_loaded;

   imem_loader_fetch #(.DEPTH_WORDS(D), .NOP_INSTR(NOP)) dut (
      .clk           (clk),
      .rst           (rst),
      .load_valid    (load_valid),
      .load_ready    (load_ready),
      .load_byte     (load_byte),
      .load_last     (load_last),
      .pc_addr       (pc_addr),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .fetch_fault   (fetch_fault),
      .load_overflow (load_overflow),
      .core_rst_n    (core_rst_n),
      .bytes_loaded  (bytes_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
      logic        fault;
   } vec_t;

   int total  = 0;
   int passed = 0;

   logic [31:0] m_mem [D];
   logic [31:0] m_asm;
   int          m_cnt;
   vec_t        sb [$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_asm = 32'h0;
   endtask

   task automatic do_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic send(input logic [7:0] b, input logic last);
      int lane;
      load_valid = 1'b1;
      load_byte  = b;
      load_last  = last;
      chk("load_ready", 32'(load_ready), 32'd1);
      tick();
      lane = m_cnt % 4;
      if (lane == 0) m_asm = 32'h0;
      m_asm[lane*8 +: 8] = b;
      if (m_cnt < CAP && (lane == 3 || last)) m_mem[m_cnt/4] = m_asm;
      m_cnt++;
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic fetch(input vec_t v);
      vec_t e;
      sb.push_back(v);
      pc_addr = v.pc;
      #1;
      e = sb.pop_front();
      chk({e.name, ".instr"}, instr, e.instr);
      chk({e.name, ".valid"}, 32'(instr_valid), 32'(e.valid));
      chk({e.name, ".fault"}, 32'(fetch_fault), 32'(e.fault));
   endtask

   task automatic fetch_m(input string name, input logic [31:0] pc);
      vec_t v;
      v.name = name;
      v.pc   = pc;
      if (pc[1:0] == 2'b00 && (pc >> 2) < 32'(D)) begin
         v.instr = m_mem[pc>>2];
         v.valid = 1'b1;
         v.fault = 1'b0;
      end else begin
         v.instr = NOP;
         v.valid = 1'b0;
         v.fault = 1'b1;
      end
      fetch(v);
   endtask

   vec_t        t1 [6];
   logic [7:0]  prog1 [8];
   logic [7:0]  prog2 [6];
   logic [31:0] exp_last;

   initial begin
      t1[0] = '{"t1_pc0",    32'd0,          32'h0010_0513, 1'b1, 1'b0};
      t1[1] = '{"t1_pc4",    32'd4,          32'h0020_0593, 1'b1, 1'b0};
      t1[2] = '{"t3_pc2",    32'd2,          NOP,           1'b0, 1'b1};
      t1[3] = '{"t3_pcdep",  32'(CAP),       NOP,           1'b0, 1'b1};
      t1[4] = '{"t3_pchigh", 32'hFFFF_FFFC,  NOP,           1'b0, 1'b1};
      t1[5] = '{"t3_pc0",    32'd0,          32'h0010_0513, 1'b1, 1'b0};
      prog1 = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
      prog2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};

      rst        = 1'b1;
      load_valid = 1'b0;
      load_byte  = 8'h0;
      load_last  = 1'b0;
      pc_addr    = 32'h2;
      model_reset();
      tick();
      tick();
      rst = 1'b0;

      // Reset state, fetch in LOAD ignores pc_addr
      chk("rst.load_ready", 32'(load_ready), 32'd1);
      chk("rst.core_rst_n", 32'(core_rst_n), 32'd0);
      chk("rst.overflow", 32'(load_overflow), 32'd0);
      chk("rst.bytes", bytes_loaded, 32'd0);
      chk("rst.instr", instr, NOP);
      chk("rst.valid", 32'(instr_valid), 32'd0);
      chk("rst.fault", 32'(fetch_fault), 32'd0);

      // Test 1 and 3
      load_last = 1'b1;
      tick();
      chk("t1.last_no_valid", 32'(load_ready), 32'd1);
      load_last = 1'b0;
      for (int i = 0; i < 8; i++) send(prog1[i], i == 7);
      chk("t1.run_ready", 32'(load_ready), 32'd0);
      chk("t1.core_still_low", 32'(core_rst_n), 32'd0);
      tick();
      chk("t1.core_high", 32'(core_rst_n), 32'd1);
      load_valid = 1'b1;
      load_byte  = 8'hFF;
      tick();
      load_valid = 1'b0;
      chk("t1.run_ignores", bytes_loaded, 32'd8);
      for (int i = 0; i < 6; i++) fetch(t1[i]);

      // Test 2
      do_rst();
      for (int i = 0; i < 6; i++) send(prog2[i], i == 5);
      chk("t2.bytes", bytes_loaded, 32'd6);
      fetch('{"t2_pc4", 32'd4, 32'h0000_2211, 1'b1, 1'b0});
      fetch('{"t2_pc0", 32'd0, 32'hDDCC_BBAA, 1'b1, 1'b0});

      // Test 4: overflow
      do_rst();
      for (int i = 0; i < CAP + 3; i++) begin
         send(8'(i * 7 + 3), i == CAP + 2);
         if (i == CAP - 1) chk("t4.no_ovf_yet", 32'(load_overflow), 32'd0);
         if (i == CAP) chk("t4.ovf_set", 32'(load_overflow), 32'd1);
      end
      chk("t4.ovf", 32'(load_overflow), 32'd1);
      chk("t4.bytes", bytes_loaded, 32'(CAP + 3));
      chk("t4.run", 32'(load_ready), 32'd0);
      exp_last = {8'((CAP-1)*7+3), 8'((CAP-2)*7+3),
                  8'((CAP-3)*7+3), 8'((CAP-4)*7+3)};
      fetch('{"t4_lastword", 32'(CAP - 4), exp_last, 1'b1, 1'b0});
      fetch_m("t4_pc8", 32'd8);

      // Test 5: reset mid-load keeps stale words
      do_rst();
      chk("t5.ovf_clr", 32'(load_overflow), 32'd0);
      for (int i = 0; i < 5; i++) send(8'(8'h60 + i), 1'b0);
      chk("t5.bytes5", bytes_loaded, 32'd5);
      do_rst();
      chk("t5.bytes0", bytes_loaded, 32'd0);
      send(8'h37, 1'b0);
      send(8'h01, 1'b0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b1);
      fetch('{"t5_pc0", 32'd0, 32'h0000_0137, 1'b1, 1'b0});
      fetch('{"t5_pc4", 32'd4, {8'(7*7+3), 8'(6*7+3), 8'(5*7+3), 8'(4*7+3)},
              1'b1, 1'b0});

      // Test 6: idle gaps, reset in RUN, reset colliding with a byte
      do_rst();
      send(8'hEF, 1'b0);
      send(8'hBE, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6.idle_bytes", bytes_loaded, 32'd2);
      end
      send(8'hAD, 1'b0);
      send(8'hDE, 1'b1);
      tick();
      fetch('{"t6_gap_word", 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b0});
      chk("t6.core_up", 32'(core_rst_n), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      chk("t6.run_rst_core", 32'(core_rst_n), 32'd0);
      chk("t6.run_rst_ready", 32'(load_ready), 32'd1);
      send(8'h55, 1'b0);
      rst        = 1'b1;
      load_valid = 1'b1;
      load_byte  = 8'h66;
      tick();
      rst        = 1'b0;
      load_valid = 1'b0;
      model_reset();
      chk("t6.col_bytes", bytes_loaded, 32'd0);
      chk("t6.col_core", 32'(core_rst_n), 32'd0);
      send(8'h93, 1'b0);
      send(8'h00, 1'b0);
      send(8'h10, 1'b0);
      send(8'h00, 1'b1);
      chk("t6.bytes4", bytes_loaded, 32'd4);
      fetch('{"t6_reload", 32'd0, 32'h0010_0093, 1'b1, 1'b0});
      fetch_m("t6_pc4_model", 32'd4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
